// File: rtl/multi_radix_hex_loser_div_div_15s_14ns_15_seq.sv
// Sequential radix-2 restoring divider: signed 15-bit dividend by unsigned 14-bit divisor,
// quotient truncated toward zero. Define DIV_REMAINDER_EN to expose the signed remainder port.
module multi_radix_hex_loser_div_div_15s_14ns_15_seq #(
   parameter int unsigned ID         = 32'd1,
   parameter int unsigned din0_WIDTH = 32'd15,
   parameter int unsigned din1_WIDTH = 32'd14,
   parameter int unsigned dout_WIDTH = 32'd15
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ce,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [dout_WIDTH-1:0] dout,
`ifdef DIV_REMAINDER_EN
   output logic [dout_WIDTH-1:0] rem,
`endif
   output logic                  div_zero,
   output logic [1:0]            dbg_state_o
);

   localparam int W0 = din0_WIDTH;
   localparam int W1 = din1_WIDTH;
   localparam int WO = dout_WIDTH;
   localparam int CW = $clog2(W0 + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          neg_q, neg_d;
   logic [W1-1:0] dsr_q, dsr_d;
   logic [W0-1:0] dvd_q, dvd_d;
   logic [W1-1:0] prem_q, prem_d;
   logic [WO-1:0] dout_q, dout_d;
   logic          dz_q, dz_d;
   logic          ov_q, ov_d;
`ifdef DIV_REMAINDER_EN
   logic [WO-1:0] rem_q, rem_d;
   logic [WO-1:0] rem_ext;
   logic [WO-1:0] rem_fix;
`endif

   logic [W0-1:0] din0_abs;
   logic [W1:0]   trial;
   logic [W1+1:0] diff;
   logic          ge;
   logic [W1-1:0] prem_nx;
   logic [WO-1:0] q_fix;
   logic [WO-1:0] dz_dout;
   logic          unused_bits;

   // Magnitude fits in W0 bits even for the most negative dividend (read as unsigned).
   assign din0_abs = din0[W0-1] ? (~din0 + {{(W0-1){1'b0}}, 1'b1}) : din0;

   assign trial   = {prem_q, dvd_q[W0-1]};
   assign diff    = {1'b0, trial} - {2'b00, dsr_q};
   assign ge      = ~diff[W1+1];
   assign prem_nx = ge ? diff[W1-1:0] : trial[W1-1:0];

   assign q_fix   = neg_q ? (~dvd_q + {{(W0-1){1'b0}}, 1'b1}) : dvd_q;
   assign dz_dout = din0[W0-1] ? {1'b1, {(WO-1){1'b0}}} : {1'b0, {(WO-1){1'b1}}};

`ifdef DIV_REMAINDER_EN
   assign rem_ext = {{(WO-W1){1'b0}}, prem_q};
   assign rem_fix = neg_q ? (~rem_ext + {{(WO-1){1'b0}}, 1'b1}) : rem_ext;
`endif

   assign unused_bits = ^{diff[W1], ID[0]};

   // Handshake: a transfer happens on an enabled posedge where valid and ready are both 1;
   // out_valid holds with stable data until taken, and in_ready is high only in IDLE.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      dsr_d   = dsr_q;
      dvd_d   = dvd_q;
      prem_d  = prem_q;
      dout_d  = dout_q;
      dz_d    = dz_q;
      ov_d    = ov_q;
`ifdef DIV_REMAINDER_EN
      rem_d   = rem_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               neg_d  = din0[W0-1];
               dsr_d  = din1;
               dvd_d  = din0_abs;
               prem_d = '0;
               if (din1 != '0) begin
                  state_d = S_CALC;
                  cnt_d   = CW'(W0);
               end else begin
                  state_d = S_DONE;
                  ov_d    = 1'b1;
                  dz_d    = 1'b1;
                  dout_d  = dz_dout;
`ifdef DIV_REMAINDER_EN
                  rem_d   = din0;
`endif
               end
            end
         end
         S_CALC: begin
            dvd_d  = {dvd_q[W0-2:0], ge};
            prem_d = prem_nx;
            cnt_d  = cnt_q - {{(CW-1){1'b0}}, 1'b1};
            if (cnt_q == CW'(1)) begin
               state_d = S_FIX;
            end
         end
         S_FIX: begin
            dout_d  = q_fix;
            dz_d    = 1'b0;
            ov_d    = 1'b1;
            state_d = S_DONE;
`ifdef DIV_REMAINDER_EN
            rem_d   = rem_fix;
`endif
         end
         S_DONE: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         neg_q   <= 1'b0;
         dsr_q   <= '0;
         dvd_q   <= '0;
         prem_q  <= '0;
         dout_q  <= '0;
         dz_q    <= 1'b0;
         ov_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
         rem_q   <= '0;
`endif
      end else if (ce) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         dsr_q   <= dsr_d;
         dvd_q   <= dvd_d;
         prem_q  <= prem_d;
         dout_q  <= dout_d;
         dz_q    <= dz_d;
         ov_q    <= ov_d;
`ifdef DIV_REMAINDER_EN
         rem_q   <= rem_d;
`endif
      end
   end

   assign in_ready    = (state_q == S_IDLE);
   assign out_valid   = ov_q;
   assign dout        = dout_q;
   assign div_zero    = dz_q;
   assign dbg_state_o = state_q;
`ifdef DIV_REMAINDER_EN
   assign rem         = rem_q;
`endif

endmodule

// File: tb/tb_multi_radix_hex_loser_div_div_15s_14ns_15_seq.sv
// Directed and randomised-ce bench for the sequential 15s/14ns divider;
// remainder checks are active when DIV_REMAINDER_EN is defined.
module tb_multi_radix_hex_loser_div_div_15s_14ns_15_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        ce;
   logic        in_valid;
   logic        in_ready;
   logic [14:0] din0;
   logic [13:0] din1;
   logic        out_valid;
   logic        out_ready;
   logic [14:0] dout;
`ifdef DIV_REMAINDER_EN
   logic [14:0] rem;
`endif
   logic        div_zero;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   logic [30:0] exp_q[$];

   always #5 clk = ~clk;

   multi_radix_hex_loser_div_div_15s_14ns_15_seq dut (
      .clk        (clk),
      .reset      (reset),
      .ce         (ce),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .din0       (din0),
      .din1       (din1),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .dout       (dout),
`ifdef DIV_REMAINDER_EN
      .rem        (rem),
`endif
      .div_zero   (div_zero),
      .dbg_state_o(dbg_state)
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation, measure enabled-cycle latency, optionally hold the result, then retire.
   task automatic do_op(input logic [14:0] a, input logic [13:0] b, input logic [14:0] eq,
                        input logic [14:0] er, input logic edz, input int exp_lat,
                        input bit rand_ce, input int hold);
      int n;
      int lat;
      bit acc;
      logic [30:0] e;
      exp_q.push_back({edz, er, eq});
      n = 0;
      while (!in_ready && n < 100) begin
         ce = 1'b1;
         tick();
         n++;
      end
      check_val("in_ready_before_op", {31'd0, in_ready}, 32'd1);
      din0 = a;
      din1 = b;
      in_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 100) begin
         ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
         acc = ce & in_ready;
         tick();
         n++;
      end
      in_valid = 1'b0;
      lat = acc ? 1 : 0;
      n = 0;
      while (!out_valid && n < 1000) begin
         ce = rand_ce ? 1'($urandom_range(0, 1)) : 1'b1;
         if (ce) lat++;
         tick();
         n++;
      end
      check_val("out_valid", {31'd0, out_valid}, 32'd1);
      check_val("latency", lat, exp_lat);
      e = exp_q.pop_front();
      check_val("dout", {17'd0, dout}, {17'd0, e[14:0]});
      check_val("div_zero", {31'd0, div_zero}, {31'd0, e[30]});
`ifdef DIV_REMAINDER_EN
      check_val("rem", {17'd0, rem}, {17'd0, e[29:15]});
`endif
      for (int i = 0; i < hold; i++) begin
         ce = 1'b1;
         tick();
         check_val("hold_out_valid", {31'd0, out_valid}, 32'd1);
         check_val("hold_dout", {17'd0, dout}, {17'd0, e[14:0]});
         check_val("hold_in_ready", {31'd0, in_ready}, 32'd0);
      end
      ce = 1'b1;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_val("retire_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("retire_idle", {30'd0, dbg_state}, 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [14:0] a;
      logic [13:0] b;
      logic [14:0] eq;
      logic [14:0] er;
      int sa;
      int q;
      int r;

      reset = 1'b0;
      ce = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      din0 = '0;
      din1 = '0;
      tick();
      tick();
      check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_val("rst_dout", {17'd0, dout}, 32'd0);
      check_val("rst_div_zero", {31'd0, div_zero}, 32'd0);
      check_val("rst_state", {30'd0, dbg_state}, 32'd0);
`ifdef DIV_REMAINDER_EN
      check_val("rst_rem", {17'd0, rem}, 32'd0);
`endif
      reset = 1'b1;
      ce = 1'b1;
      tick();

      // Directed vectors with hand-computed results.
      do_op(15'd100,   14'd7,     15'd14,   15'd2,    1'b0, 17, 1'b0, 0);
      do_op(15'h7F9C,  14'd7,     15'h7FF2, 15'h7FFE, 1'b0, 17, 1'b0, 0);
      do_op(15'h4000,  14'd1,     15'h4000, 15'd0,    1'b0, 17, 1'b0, 0);
      do_op(15'd16383, 14'd16383, 15'd1,    15'd0,    1'b0, 17, 1'b0, 0);
      do_op(15'd5,     14'd16383, 15'd0,    15'd5,    1'b0, 17, 1'b0, 0);
      do_op(15'h7FFB,  14'd0,     15'h4000, 15'h7FFB, 1'b1, 1,  1'b0, 0);
      do_op(15'd9,     14'd0,     15'h3FFF, 15'd9,    1'b1, 1,  1'b0, 0);
      do_op(15'd16383, 14'd2,     15'd8191, 15'd1,    1'b0, 17, 1'b0, 0);
      do_op(15'h7FFF,  14'd3,     15'd0,    15'h7FFF, 1'b0, 17, 1'b0, 0);

      // Back-pressure: result held for 10 cycles with out_ready low.
      do_op(15'd100,   14'd7,     15'd14,   15'd2,    1'b0, 17, 1'b0, 10);

      // Reset during CALC once the counter has reached 8, with ce low.
      din0 = 15'd100;
      din1 = 14'd7;
      in_valid = 1'b1;
      ce = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      check_val("mid_calc_state", {30'd0, dbg_state}, 32'd1);
      reset = 1'b0;
      ce = 1'b0;
      tick();
      reset = 1'b1;
      ce = 1'b1;
      check_val("abort_state", {30'd0, dbg_state}, 32'd0);
      check_val("abort_in_ready", {31'd0, in_ready}, 32'd1);
      check_val("abort_out_valid", {31'd0, out_valid}, 32'd0);
      do_op(15'd100,   14'd7,     15'd14,   15'd2,    1'b0, 17, 1'b0, 0);

      // Random operands with ce toggled at random; results from an integer model.
      for (int k = 0; k < 200; k++) begin
         a = 15'($urandom_range(0, 32767));
         b = ($urandom_range(0, 15) == 0) ? 14'd0 : 14'($urandom_range(1, 16383));
         sa = int'($signed(a));
         if (b == 14'd0) begin
            eq = (sa >= 0) ? 15'h3FFF : 15'h4000;
            do_op(a, b, eq, a, 1'b1, 1, 1'b1, 0);
         end else begin
            q = sa / int'(b);
            r = sa % int'(b);
            eq = q[14:0];
            er = r[14:0];
            do_op(a, b, eq, er, 1'b0, 17, 1'b1, 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
